// File: rtl/core_trace_monitor.sv
// core_trace_monitor: retire-trace FIFO with cycle/retire/drop counters, program-end
// detection (EBREAK / jump-to-self) and a no-retire watchdog. Never back-pressures the core.
// Build option: define TRACE_OVERWRITE_EN to make overflow evict the oldest entry instead of
// discarding the newly retired one.
module core_trace_monitor #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned PC_W           = 32,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      retire_valid,
  input  logic [PC_W-1:0]           retire_pc,
  input  logic [31:0]               retire_inst,
  input  logic [XLEN-1:0]           retire_rd,
  input  logic [XLEN-1:0]           retire_alu,
  output logic                      trace_valid,
  input  logic                      trace_ready,
  output logic [PC_W+32+2*XLEN-1:0] trace_data,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [CNT_W-1:0]          retire_count,
  output logic [15:0]               drop_count,
  output logic                      halted,
  output logic                      timeout
);

  localparam int unsigned DW     = PC_W + 32 + 2 * XLEN;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PTR_W  = AW + 1;
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] INST_EBREAK   = 32'h0010_0073;
  localparam logic [31:0] INST_JAL_SELF = 32'h0000_006F;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              valid_q, valid_d;
  logic [DW-1:0]     head_q, head_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [15:0]       drop_q, drop_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [IDLE_W-1:0] idle_inc;
  logic [DW-1:0]     mem_q [DEPTH];

  logic              push, pop, full, wr_en, is_halt_inst;
  logic [DW-1:0]     new_entry;
  logic [AW-1:0]     wr_idx;

  assign trace_valid  = valid_q;
  assign trace_data   = head_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign drop_count   = drop_q;
  assign halted       = (state_q == ST_HALTED);
  assign timeout      = (state_q == ST_TIMEOUT);

  // Next-state, FIFO pointer, counter and registered-head computation
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cycle_d  = cycle_q;
    retire_d = retire_q;
    drop_d   = drop_q;
    idle_d   = idle_q;
    wr_en    = 1'b0;

    new_entry    = {retire_pc, retire_inst, retire_rd, retire_alu};
    wr_idx       = wr_ptr_q[AW-1:0];
    push         = retire_valid && (state_q == ST_RUN);
    pop          = valid_q && trace_ready;
    full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    is_halt_inst = (retire_inst == INST_EBREAK) || (retire_inst == INST_JAL_SELF);
    idle_inc     = idle_q + IDLE_W'(1);

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      retire_d = retire_q + CNT_W'(1);
      if (!full || pop) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
`ifdef TRACE_OVERWRITE_EN
        // Evict the oldest entry: the write lands in the slot the head just vacated
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
`endif
        if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end
    end

    if (state_q == ST_RUN) begin
      cycle_d = cycle_q + CNT_W'(1);
      if (retire_valid) begin
        idle_d = '0;
        if (is_halt_inst) begin
          state_d = ST_HALTED;
        end
      end else if (TIMEOUT_CYCLES != 0) begin
        idle_d = idle_inc;
        if (idle_inc == IDLE_W'(TIMEOUT_CYCLES)) begin
          state_d = ST_TIMEOUT;
        end
      end
    end

    // Head register: the new entry bypasses the array when it lands in the next head slot
    valid_d = (wr_ptr_d != rd_ptr_d);
    if (wr_en && (rd_ptr_d[AW-1:0] == wr_idx)) begin
      head_d = new_entry;
    end else begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // State, pointer and counter registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      cycle_q  <= '0;
      retire_q <= '0;
      drop_q   <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
      drop_q   <= drop_d;
      idle_q   <= idle_d;
    end
  end

  // Trace storage array; contents are meaningless until written, so no reset
  always_ff @(posedge CLK) begin
    if (wr_en && !RESET) begin
      mem_q[wr_idx] <= new_entry;
    end
  end

endmodule

// File: tb/tb_core_trace_monitor.sv
// Bench for core_trace_monitor: directed scenarios plus randomized traffic, checked against a
// queue-based reference model through a scoreboard drained by an independent monitor process.
module tb_core_trace_monitor;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned TO    = 8;
  localparam int unsigned DW    = PC_W + 32 + 2 * XLEN;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] JSELF  = 32'h0000_006F;

  typedef logic [DW-1:0] entry_t;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             retire_valid = 1'b0;
  logic [PC_W-1:0]  retire_pc = '0;
  logic [31:0]      retire_inst = '0;
  logic [XLEN-1:0]  retire_rd = '0;
  logic [XLEN-1:0]  retire_alu = '0;
  logic             trace_ready = 1'b0;
  logic             trace_valid;
  logic [DW-1:0]    trace_data;
  logic [CNT_W-1:0] cycle_count, retire_count;
  logic [15:0]      drop_count;
  logic             halted, timeout;

  core_trace_monitor #(
    .XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_inst(retire_inst),
    .retire_rd(retire_rd), .retire_alu(retire_alu),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .cycle_count(cycle_count), .retire_count(retire_count), .drop_count(drop_count),
    .halted(halted), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  // Reference model: 0 = running, 1 = halted, 2 = timed out
  entry_t      exp_q[$];
  int          m_state = 0;
  int unsigned m_idle = 0, m_cycle = 0, m_retire = 0, m_drop = 0;

  // Expected outputs for the current cycle, published by the driver for the monitor
  bit          e_valid = 0, e_halt = 0, e_to = 0;
  int unsigned e_cycle = 0, e_retire = 0, e_drop = 0;
  bit          chk_en = 0;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void cmp(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] rinst();
    logic [31:0] v;
    v = $urandom;
    if (v == EBREAK || v == JSELF) v = v ^ 32'h100;
    return v;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_state  = 0;
    m_idle   = 0;
    m_cycle  = 0;
    m_retire = 0;
    m_drop   = 0;
  endfunction

  // One clock of stimulus: publish expectations, drive inputs, advance the model
  task automatic cyc(input bit rst, input bit rv, input logic [31:0] pc,
                     input logic [31:0] inst, input bit rdy);
    entry_t      e;
    bit          pop;
    logic [31:0] rd, alu;
    rd  = $urandom;
    alu = $urandom;
    @(posedge CLK);
    #2;
    e_valid  = (exp_q.size() > 0);
    e_cycle  = m_cycle;
    e_retire = m_retire;
    e_drop   = m_drop;
    e_halt   = (m_state == 1);
    e_to     = (m_state == 2);
    chk_en   = 1;
    RESET        = rst;
    retire_valid = rv;
    retire_pc    = pc;
    retire_inst  = inst;
    retire_rd    = rd;
    retire_alu   = alu;
    trace_ready  = rdy;
    e = {pc, inst, rd, alu};
    if (rst) begin
      model_reset();
      return;
    end
    pop = (exp_q.size() > 0) && rdy;
    if (m_state == 0) begin
      m_cycle++;
      if (rv) begin
        m_retire++;
        m_idle = 0;
        if (exp_q.size() < DEPTH || pop) begin
          exp_q.push_back(e);
        end else begin
`ifdef TRACE_OVERWRITE_EN
          void'(exp_q.pop_front());
          exp_q.push_back(e);
`endif
          if (m_drop < 65535) m_drop++;
        end
        if (inst == EBREAK || inst == JSELF) m_state = 1;
      end else begin
        m_idle++;
        if (m_idle == TO) m_state = 2;
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, rdy);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each handshake
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        cmp("trace_valid", trace_valid, e_valid);
        cmp("cycle_count", cycle_count, e_cycle);
        cmp("retire_count", retire_count, e_retire);
        cmp("drop_count", drop_count, e_drop);
        cmp("halted", halted, e_halt);
        cmp("timeout", timeout, e_to);
        if (!RESET && trace_valid && trace_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_unexpected: got data %0h expected no entry", trace_data);
          end else begin
            cmp("trace_data", trace_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int prv, prdy;
    logic [31:0] pc;

    // Five retires held, then drained in order
    cyc(1, 0, '0, '0, 0);
    cyc(1, 0, '0, '0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'(4 * i), rinst(), 0);
    idle(8, 1);
    @(negedge CLK); #1;
    cmp("s1_retire_count", retire_count, 32'd5);
    cmp("s1_drained", trace_valid, 1'b0);

    // Overflow: 20 retires into 16 entries
    cyc(1, 0, '0, '0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 32'(4 * i), rinst(), 0);
    idle(1, 0);
    @(negedge CLK); #1;
    cmp("s2_drop_count", drop_count, 16'd4);
    idle(20, 1);

    // Full FIFO with simultaneous retire and pop: no drop
    cyc(1, 0, '0, '0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 32'(4 * i), rinst(), 0);
    cyc(0, 1, 32'd64, rinst(), 1);
    idle(1, 0);
    @(negedge CLK); #1;
    cmp("s3_drop_count", drop_count, 16'd0);
    cmp("s3_valid", trace_valid, 1'b1);
    idle(20, 1);

    // EBREAK halts; later retires ignored, cycle count frozen
    cyc(1, 0, '0, '0, 0);
    cyc(0, 1, 32'h38, rinst(), 0);
    cyc(0, 1, 32'h3C, rinst(), 0);
    cyc(0, 1, 32'h40, EBREAK, 0);
    cyc(0, 1, 32'h44, rinst(), 0);
    @(negedge CLK); #1;
    cmp("s4_halted", halted, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'(32'h48 + 4 * i), rinst(), 0);
    @(negedge CLK); #1;
    cmp("s4_cycle_frozen", cycle_count, 32'd3);
    cmp("s4_retire_frozen", retire_count, 32'd3);
    idle(6, 1);

    // Watchdog fires after the 8th idle edge, not the 7th
    cyc(1, 0, '0, '0, 0);
    cyc(0, 1, 32'h100, rinst(), 0);
    idle(8, 0);
    @(negedge CLK); #1;
    cmp("s5_no_timeout_7", timeout, 1'b0);
    idle(1, 0);
    @(negedge CLK); #1;
    cmp("s5_timeout_8", timeout, 1'b1);
    cmp("s5_not_halted", halted, 1'b0);

    // A retire in the 7th idle cycle restarts the watchdog
    cyc(1, 0, '0, '0, 1);
    cyc(0, 1, 32'h200, rinst(), 0);
    idle(6, 0);
    cyc(0, 1, 32'h204, rinst(), 0);
    idle(7, 0);
    @(negedge CLK); #1;
    cmp("s6_no_timeout", timeout, 1'b0);
    idle(20, 1);

    // Reset while halted with three entries queued
    cyc(1, 0, '0, '0, 0);
    cyc(0, 1, 32'h10, rinst(), 0);
    cyc(0, 1, 32'h14, rinst(), 0);
    cyc(0, 1, 32'h18, JSELF, 0);
    idle(2, 0);
    cyc(1, 0, '0, '0, 0);
    idle(1, 0);
    @(negedge CLK); #1;
    cmp("s7_valid", trace_valid, 1'b0);
    cmp("s7_halted", halted, 1'b0);
    cmp("s7_cycle", cycle_count, 32'd0);
    cmp("s7_retire", retire_count, 32'd0);

    // Randomized segments with varying retire and ready densities
    for (int s = 0; s < 16; s++) begin
      cyc(1, 0, '0, '0, $urandom_range(0, 1));
      prv  = (s % 4 == 0) ? 95 : (s % 4 == 1) ? 60 : (s % 4 == 2) ? 30 : 8;
      prdy = (s % 3 == 0) ? 90 : (s % 3 == 1) ? 40 : 5;
      pc   = '0;
      for (int i = 0; i < 120; i++) begin
        logic [31:0] inst;
        inst = ($urandom_range(0, 199) == 0) ? (($urandom_range(0, 1) == 0) ? EBREAK : JSELF)
                                             : rinst();
        cyc(0, $urandom_range(0, 99) < prv, pc, inst, $urandom_range(0, 99) < prdy);
        pc = pc + 32'd4;
      end
      idle(20, 1);
    end

    idle(2, 0);
    @(negedge CLK); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
